// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encodings,
// opcode/funct constants, exception cause codes and ALUOp encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_REX    = 4'd2,
    S_RWB    = 4'd3,
    S_MEMADR = 4'd4,
    S_LWMEM  = 4'd5,
    S_LWWB   = 4'd6,
    S_SWMEM  = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BEQ    = 4'd10,
    S_J      = 4'd11,
    S_ERR    = 4'd12,
    S_ERET   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ERET  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_OV   = 2'd1;
  localparam logic [1:0] CAUSE_RI   = 2'd2;
  localparam logic [1:0] CAUSE_BUS  = 2'd3;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Low three ALUOp bits outside IF/ID, selected by opcode.
  function automatic logic [2:0] alu_func(input logic [5:0] op);
    logic [2:0] f;
    f = ALU_ADD;
    case (op)
      OP_RTYPE:          f = ALU_RTYPE;
      OP_BEQ:            f = ALU_SUB;
      OP_ANDI:           f = ALU_AND;
      OP_SLTI, OP_SLTIU: f = ALU_SLT;
      default:           f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (entry into a memory-wait state)
//   inc        : count one more cycle without MemReady
//   timeout    : count has reached MEM_TIMEOUT
module mc_wait_timer
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  // MEM_TIMEOUT is at most 255; the FSM leaves the wait state on a match,
  // so the count never needs to pass it.
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign timeout = (cnt == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_ctrl_stall.sv
// Multi-cycle CPU control FSM with variable-latency memory handshake.
// Fetch and load/store wait on MemReady; a wait-state timeout raises a
// bus exception. Overflow, reserved-instruction and bus-timeout causes
// are recorded in Cause.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   OpCode, Funct         : instruction register fields
//   Err                   : ALU overflow, sampled in REX/IEX
//   MemReady              : memory completes the access this cycle
//   PCWrite..PCErrSource  : datapath controls (same as previous generation)
//   ALUOp                 : {OpCode[0], function select}
//   Cause                 : cause code of the last exception
//   State                 : current state encoding (debug)
module mc_ctrl_stall
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CAUSE_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Err,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic               EPCWrite,
  output logic               ErrTargetWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         PCErrSource,
  output logic [3:0]         ALUOp,
  output logic [CAUSE_W-1:0] Cause,
  output logic [3:0]         State
);

  state_t             state, state_next;
  logic [CAUSE_W-1:0] cause_q, cause_next;
  logic               timeout;
  logic               mem_wait;

  assign mem_wait = (state == S_IF) || (state == S_LWMEM) || (state == S_SWMEM);

  // Counter restarts whenever the FSM changes state, so every entry into
  // IF/LWMEM/SWMEM begins at zero.
  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_next != state),
    .inc     (mem_wait && !MemReady),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IF;
      cause_q <= '0;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
    end
  end

  // Everything is forced low while reset is high, including the IF strobes.
  assign State = reset ? 4'd0 : state;
  assign Cause = reset ? '0 : cause_q;

  always_comb begin
    state_next     = state;
    cause_next     = cause_q;
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    IorD           = 1'b0;
    MemWrite       = 1'b0;
    MemRead        = 1'b0;
    IRWrite        = 1'b0;
    RegWrite       = 1'b0;
    ExtOp          = 1'b0;
    LuiOp          = 1'b0;
    EPCWrite       = 1'b0;
    ErrTargetWrite = 1'b0;
    MemtoReg       = 2'b00;
    RegDst         = 2'b00;
    ALUSrcA        = 2'b00;
    ALUSrcB        = 2'b00;
    PCSource       = 2'b00;
    PCErrSource    = 2'b00;
    ALUOp          = 4'b0000;

    if (!reset) begin
      ALUOp[3] = OpCode[0];
      if (state != S_IF && state != S_ID) begin
        ALUOp[2:0] = alu_func(OpCode);
      end

      case (state)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          // A ready in the timeout cycle still completes the fetch.
          if (MemReady) begin
            PCWrite    = 1'b1;
            IRWrite    = 1'b1;
            state_next = S_ID;
          end else if (timeout) begin
            state_next = S_ERR;
            cause_next = CAUSE_W'(CAUSE_BUS);
          end
        end

        S_ID: begin
          ALUSrcB = 2'b11;
          ExtOp   = 1'b1;
          case (OpCode)
            OP_ERET:  state_next = S_ERET;
            OP_RTYPE: state_next = (Funct == FN_JR || Funct == FN_JALR) ? S_J : S_REX;
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU: state_next = S_IEX;
            OP_BEQ:   state_next = S_BEQ;
            OP_J, OP_JAL: state_next = S_J;
            default: begin
              state_next = S_ERR;
              cause_next = CAUSE_W'(CAUSE_RI);
            end
          endcase
        end

        S_REX: begin
          // Shifts take the shamt path on operand A.
          ALUSrcA = (Funct == FN_SLL || Funct == FN_SRL || Funct == FN_SRA) ? 2'b10 : 2'b01;
          if (Err) begin
            state_next = S_ERR;
            cause_next = CAUSE_W'(CAUSE_OV);
          end else begin
            state_next = S_RWB;
          end
        end

        S_IEX: begin
          ALUSrcB = 2'b10;
          LuiOp   = (OpCode == OP_LUI);
          ExtOp   = (OpCode != OP_ANDI);
          if (Err) begin
            state_next = S_ERR;
            cause_next = CAUSE_W'(CAUSE_OV);
          end else begin
            state_next = S_IWB;
          end
        end

        S_RWB: begin
          RegWrite   = 1'b1;
          RegDst     = 2'b01;
          MemtoReg   = 2'b01;
          state_next = S_IF;
        end

        S_IWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 2'b01;
          state_next = S_IF;
        end

        S_MEMADR: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ExtOp      = 1'b1;
          state_next = (OpCode == OP_LW) ? S_LWMEM : S_SWMEM;
        end

        S_LWMEM, S_SWMEM: begin
          IorD     = 1'b1;
          MemRead  = (state == S_LWMEM);
          MemWrite = (state == S_SWMEM);
          if (MemReady) begin
            state_next = (state == S_LWMEM) ? S_LWWB : S_IF;
          end else if (timeout) begin
            state_next = S_ERR;
            cause_next = CAUSE_W'(CAUSE_BUS);
          end
        end

        S_LWWB: begin
          RegWrite   = 1'b1;
          state_next = S_IF;
        end

        S_BEQ: begin
          ALUSrcA     = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          state_next  = S_IF;
        end

        S_J: begin
          PCWrite  = 1'b1;
          PCSource = (OpCode == OP_RTYPE) ? 2'b11 : 2'b10;
          // Link variants write the return address.
          if (OpCode == OP_JAL || (OpCode == OP_RTYPE && Funct == FN_JALR)) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
          state_next = S_IF;
        end

        S_ERR: begin
          PCWrite        = 1'b1;
          EPCWrite       = 1'b1;
          ErrTargetWrite = 1'b1;
          PCErrSource    = 2'b01;
          state_next     = S_IF;
        end

        S_ERET: begin
          PCWrite     = 1'b1;
          PCErrSource = 2'b10;
          RegWrite    = 1'b1;
          RegDst      = 2'b11;
          MemtoReg    = 2'b11;
          state_next  = S_IF;
        end

        default: state_next = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_stall.sv
module tb_mc_ctrl_stall;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OpCode = 6'h08;
  logic [5:0] Funct = 6'h00;
  logic       Err = 1'b0;
  logic       MemReady = 1'b1;
  logic PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite;
  logic ExtOp, LuiOp, EPCWrite, ErrTargetWrite;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, PCErrSource;
  logic [3:0] ALUOp;
  logic [1:0] Cause;
  logic [3:0] State;

  always #5 clk = ~clk;

  mc_ctrl_stall #(.MEM_TIMEOUT(15), .CAUSE_W(2)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Err(Err),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp), .EPCWrite(EPCWrite),
    .ErrTargetWrite(ErrTargetWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCErrSource(PCErrSource), .ALUOp(ALUOp), .Cause(Cause), .State(State)
  );

  // Control outputs packed into one word, PCWrite at bit 0.
  logic [26:0] ctl;
  assign ctl = {ALUOp, PCErrSource, PCSource, ALUSrcB, ALUSrcA, RegDst, MemtoReg,
                ErrTargetWrite, EPCWrite, LuiOp, ExtOp, RegWrite, IRWrite,
                MemRead, MemWrite, IorD, PCWriteCond, PCWrite};

  localparam logic [26:0] K_PCW  = 27'h001;
  localparam logic [26:0] K_PCWC = 27'h002;
  localparam logic [26:0] K_IORD = 27'h004;
  localparam logic [26:0] K_MW   = 27'h008;
  localparam logic [26:0] K_MR   = 27'h010;
  localparam logic [26:0] K_IRW  = 27'h020;
  localparam logic [26:0] K_RW   = 27'h040;
  localparam logic [26:0] K_EXT  = 27'h080;
  localparam logic [26:0] K_LUI  = 27'h100;
  localparam logic [26:0] K_EPC  = 27'h200;
  localparam logic [26:0] K_ETW  = 27'h400;

  function automatic logic [26:0] m2r(input logic [1:0] v); return 27'(v) << 11; endfunction
  function automatic logic [26:0] dst(input logic [1:0] v); return 27'(v) << 13; endfunction
  function automatic logic [26:0] sa (input logic [1:0] v); return 27'(v) << 15; endfunction
  function automatic logic [26:0] sb (input logic [1:0] v); return 27'(v) << 17; endfunction
  function automatic logic [26:0] pcs(input logic [1:0] v); return 27'(v) << 19; endfunction
  function automatic logic [26:0] pes(input logic [1:0] v); return 27'(v) << 21; endfunction
  function automatic logic [26:0] aop(input logic [3:0] v); return 27'(v) << 23; endfunction
  // Fetch completing with MemReady, and decode; odd selects ALUOp[3].
  function automatic logic [26:0] c_if(input logic odd);
    return K_MR | sb(2'b01) | K_PCW | K_IRW | aop({odd, 3'b000});
  endfunction
  function automatic logic [26:0] c_id(input logic odd);
    return sb(2'b11) | K_EXT | aop({odd, 3'b000});
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        err;
    logic        rdy;
    logic [3:0]  st;
    logic [1:0]  cause;
    logic [26:0] ctl;
  } rec_t;

  rec_t vec[$];
  rec_t sb_q[$];
  rec_t e;
  int   checks = 0;
  int   errors = 0;
  int   stepno = 0;

  task automatic v(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                   input logic err, input logic rdy, input state_t st,
                   input logic [1:0] cause, input logic [26:0] c);
    rec_t r;
    r.rst = rst; r.op = op; r.fn = fn; r.err = err; r.rdy = rdy;
    r.st = st; r.cause = cause; r.ctl = c;
    vec.push_back(r);
  endtask

  // Drive one cycle's inputs, queue its expectation, compare at negedge.
  task automatic step(input rec_t r);
    @(posedge clk);
    #1;
    reset = r.rst; OpCode = r.op; Funct = r.fn; Err = r.err; MemReady = r.rdy;
    sb_q.push_back(r);
    @(negedge clk);
    e = sb_q.pop_front();
    checks = checks + 3;
    if (State !== e.st) begin
      errors = errors + 1;
      $display("FAIL step%0d state got %0d want %0d", stepno, State, e.st);
    end
    if (Cause !== e.cause) begin
      errors = errors + 1;
      $display("FAIL step%0d cause got %0d want %0d", stepno, Cause, e.cause);
    end
    if (ctl !== e.ctl) begin
      errors = errors + 1;
      $display("FAIL step%0d ctl got %07h want %07h", stepno, ctl, e.ctl);
    end
    stepno = stepno + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    // reset
    v(1, 6'h08, 6'h00, 0, 1, S_IF, 0, 27'h0);
    v(1, 6'h08, 6'h00, 0, 1, S_IF, 0, 27'h0);
    // addi, zero wait states
    v(0, 6'h08, 6'h00, 0, 1, S_IF,  0, c_if(0));
    v(0, 6'h08, 6'h00, 0, 1, S_ID,  0, c_id(0));
    v(0, 6'h08, 6'h00, 0, 1, S_IEX, 0, sb(2) | K_EXT);
    v(0, 6'h08, 6'h00, 0, 1, S_IWB, 0, K_RW | m2r(1));
    // lw with three wait cycles
    v(0, 6'h23, 6'h00, 0, 1, S_IF,     0, c_if(1));
    v(0, 6'h23, 6'h00, 0, 1, S_ID,     0, c_id(1));
    v(0, 6'h23, 6'h00, 0, 1, S_MEMADR, 0, sa(1) | sb(2) | K_EXT | aop(8));
    v(0, 6'h23, 6'h00, 0, 0, S_LWMEM,  0, K_IORD | K_MR | aop(8));
    v(0, 6'h23, 6'h00, 0, 0, S_LWMEM,  0, K_IORD | K_MR | aop(8));
    v(0, 6'h23, 6'h00, 0, 0, S_LWMEM,  0, K_IORD | K_MR | aop(8));
    v(0, 6'h23, 6'h00, 0, 1, S_LWMEM,  0, K_IORD | K_MR | aop(8));
    v(0, 6'h23, 6'h00, 0, 1, S_LWWB,   0, K_RW | aop(8));
    // sw with one wait cycle
    v(0, 6'h2b, 6'h00, 0, 1, S_IF,     0, c_if(1));
    v(0, 6'h2b, 6'h00, 0, 1, S_ID,     0, c_id(1));
    v(0, 6'h2b, 6'h00, 0, 1, S_MEMADR, 0, sa(1) | sb(2) | K_EXT | aop(8));
    v(0, 6'h2b, 6'h00, 0, 0, S_SWMEM,  0, K_IORD | K_MW | aop(8));
    v(0, 6'h2b, 6'h00, 0, 1, S_SWMEM,  0, K_IORD | K_MW | aop(8));
    // beq
    v(0, 6'h04, 6'h00, 0, 1, S_IF,  0, c_if(0));
    v(0, 6'h04, 6'h00, 0, 1, S_ID,  0, c_id(0));
    v(0, 6'h04, 6'h00, 0, 1, S_BEQ, 0, sa(1) | K_PCWC | pcs(1) | aop(1));
    // j
    v(0, 6'h02, 6'h00, 0, 1, S_IF, 0, c_if(0));
    v(0, 6'h02, 6'h00, 0, 1, S_ID, 0, c_id(0));
    v(0, 6'h02, 6'h00, 0, 1, S_J,  0, K_PCW | pcs(2));
    // jal
    v(0, 6'h03, 6'h00, 0, 1, S_IF, 0, c_if(1));
    v(0, 6'h03, 6'h00, 0, 1, S_ID, 0, c_id(1));
    v(0, 6'h03, 6'h00, 0, 1, S_J,  0, K_PCW | pcs(2) | K_RW | dst(2) | m2r(2) | aop(8));
    // jr
    v(0, 6'h00, 6'h08, 0, 1, S_IF, 0, c_if(0));
    v(0, 6'h00, 6'h08, 0, 1, S_ID, 0, c_id(0));
    v(0, 6'h00, 6'h08, 0, 1, S_J,  0, K_PCW | pcs(3) | aop(2));
    // jalr
    v(0, 6'h00, 6'h09, 0, 1, S_IF, 0, c_if(0));
    v(0, 6'h00, 6'h09, 0, 1, S_ID, 0, c_id(0));
    v(0, 6'h00, 6'h09, 0, 1, S_J,  0, K_PCW | pcs(3) | K_RW | dst(2) | m2r(2) | aop(2));
    // sll takes the shift operand path
    v(0, 6'h00, 6'h00, 0, 1, S_IF,  0, c_if(0));
    v(0, 6'h00, 6'h00, 0, 1, S_ID,  0, c_id(0));
    v(0, 6'h00, 6'h00, 0, 1, S_REX, 0, sa(2) | aop(2));
    v(0, 6'h00, 6'h00, 0, 1, S_RWB, 0, K_RW | dst(1) | m2r(1) | aop(2));
    // andi zero-extends
    v(0, 6'h0c, 6'h00, 0, 1, S_IF,  0, c_if(0));
    v(0, 6'h0c, 6'h00, 0, 1, S_ID,  0, c_id(0));
    v(0, 6'h0c, 6'h00, 0, 1, S_IEX, 0, sb(2) | aop(4));
    v(0, 6'h0c, 6'h00, 0, 1, S_IWB, 0, K_RW | m2r(1) | aop(4));
    // lui
    v(0, 6'h0f, 6'h00, 0, 1, S_IF,  0, c_if(1));
    v(0, 6'h0f, 6'h00, 0, 1, S_ID,  0, c_id(1));
    v(0, 6'h0f, 6'h00, 0, 1, S_IEX, 0, sb(2) | K_LUI | K_EXT | aop(8));
    v(0, 6'h0f, 6'h00, 0, 1, S_IWB, 0, K_RW | m2r(1) | aop(8));
    // sltiu
    v(0, 6'h0b, 6'h00, 0, 1, S_IF,  0, c_if(1));
    v(0, 6'h0b, 6'h00, 0, 1, S_ID,  0, c_id(1));
    v(0, 6'h0b, 6'h00, 0, 1, S_IEX, 0, sb(2) | K_EXT | aop(13));
    v(0, 6'h0b, 6'h00, 0, 1, S_IWB, 0, K_RW | m2r(1) | aop(13));
    // reserved instruction, then eret
    v(0, 6'h3f, 6'h00, 0, 1, S_IF,   0, c_if(1));
    v(0, 6'h3f, 6'h00, 0, 1, S_ID,   0, c_id(1));
    v(0, 6'h3f, 6'h00, 0, 1, S_ERR,  2, K_PCW | K_EPC | K_ETW | pes(1) | aop(8));
    v(0, 6'h01, 6'h00, 0, 1, S_IF,   2, c_if(1));
    v(0, 6'h01, 6'h00, 0, 1, S_ID,   2, c_id(1));
    v(0, 6'h01, 6'h00, 0, 1, S_ERET, 2, K_PCW | pes(2) | K_RW | dst(3) | m2r(3) | aop(8));
    // add overflow
    v(0, 6'h00, 6'h20, 0, 1, S_IF,  2, c_if(0));
    v(0, 6'h00, 6'h20, 0, 1, S_ID,  2, c_id(0));
    v(0, 6'h00, 6'h20, 1, 1, S_REX, 2, sa(1) | aop(2));
    v(0, 6'h00, 6'h20, 0, 1, S_ERR, 1, K_PCW | K_EPC | K_ETW | pes(1) | aop(2));
    // reset asserted during LWMEM
    v(0, 6'h23, 6'h00, 0, 1, S_IF,     1, c_if(1));
    v(0, 6'h23, 6'h00, 0, 1, S_ID,     1, c_id(1));
    v(0, 6'h23, 6'h00, 0, 1, S_MEMADR, 1, sa(1) | sb(2) | K_EXT | aop(8));
    v(0, 6'h23, 6'h00, 0, 0, S_LWMEM,  1, K_IORD | K_MR | aop(8));
    v(1, 6'h23, 6'h00, 0, 0, S_IF,     0, 27'h0);
    v(0, 6'h23, 6'h00, 0, 0, S_IF,     0, K_MR | sb(1) | aop(8));

    foreach (vec[i]) step(vec[i]);

    // Fetch timeout: 16 IF cycles without MemReady, then ERR with BUS cause.
    r.rst = 1; r.op = 6'h08; r.fn = 6'h00; r.err = 0; r.rdy = 0;
    r.st = S_IF; r.cause = 0; r.ctl = 27'h0;
    step(r);
    r.rst = 0; r.ctl = K_MR | sb(1);
    for (int i = 0; i < 16; i++) step(r);
    r.st = S_ERR; r.cause = 3; r.ctl = K_PCW | K_EPC | K_ETW | pes(1);
    step(r);
    r.rdy = 1; r.st = S_IF; r.ctl = c_if(0);
    step(r);

    // Wait-state boundary: ready on the 16th LWMEM cycle still completes.
    r.op = 6'h23; r.st = S_ID; r.ctl = c_id(1);
    step(r);
    r.st = S_MEMADR; r.ctl = sa(1) | sb(2) | K_EXT | aop(8);
    step(r);
    r.rdy = 0; r.st = S_LWMEM; r.ctl = K_IORD | K_MR | aop(8);
    for (int i = 0; i < 15; i++) step(r);
    r.rdy = 1;
    step(r);
    r.st = S_LWWB; r.ctl = K_RW | aop(8);
    step(r);

    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_stall.md
# mc_ctrl_stall

Multi-cycle CPU control FSM with a variable-latency memory handshake. It replaces the fixed single-cycle-memory controller in the multi-cycle datapath. Fetch and load/store states wait on `MemReady`, and a parametrised bus timeout raises an exception. A cause register records overflow, reserved-instruction and bus-timeout exceptions. The block drives the same datapath control signals as the previous generation, so datapath muxes are unchanged.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: wait cycles allowed in a memory state before a bus-timeout exception; legal range 1..255.
- `CAUSE_W`, 2: width of the exception cause code.

Ports:
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `OpCode` in 6, `Funct` in 6: fields from the instruction register.
- `Err` in 1: ALU overflow flag, sampled in REX/IEX.
- `MemReady` in 1: memory completes the current access this cycle.
- Datapath controls, out: `PCWrite`, `PCWriteCond`, `IorD`, `MemWrite`, `MemRead`, `IRWrite`, `RegWrite`, `ExtOp`, `LuiOp`, `EPCWrite`, `ErrTargetWrite` (1 bit each); `MemtoReg`, `RegDst`, `ALUSrcA`, `ALUSrcB`, `PCSource`, `PCErrSource` (2 bits each); `ALUOp` (4 bits).
- `Cause` out CAUSE_W: registered cause of the last exception.
- `State` out 4: current state encoding, for debug.

## Operation
- States: IF, ID, REX, RWB, MEMADR, LWMEM, LWWB, SWMEM, IEX, IWB, BEQ, J, ERR, ERET.
- IF:
  - `MemRead`=1, `ALUSrcB`=01 for the whole fetch.
  - `PCWrite`=1 and `IRWrite`=1 only in the cycle `MemReady`=1; that cycle moves to ID.
- ID decodes to the next state:
  - 0x01 → ERET.
  - R-type with Funct jr (0x08) or jalr (0x09) → J; other R-type → REX.
  - lw (0x23) / sw (0x2b) → MEMADR.
  - lui 0f, addi 08, addiu 09, andi 0c, slti 0a, sltiu 0b → IEX.
  - beq 04 → BEQ; j 02 / jal 03 → J.
  - Any other opcode → ERR with cause RI.
- ID outputs: `ALUSrcB`=11, `ExtOp`=1.
- REX / IEX: `Err`=1 → ERR with cause OV; otherwise → RWB / IWB.
  - REX: `ALUSrcA`=10 for sll/srl/sra (Funct 00/02/03), else 01.
  - IEX: `ALUSrcB`=10; `LuiOp`=1 for lui; `ExtOp`=0 for andi, else 1.
- RWB: `RegWrite`=1, `RegDst`=01, `MemtoReg`=01. IWB: `RegWrite`=1, `RegDst`=00, `MemtoReg`=01.
- MEMADR: `ALUSrcA`=01, `ALUSrcB`=10, `ExtOp`=1; → LWMEM for lw, SWMEM for sw.
- LWMEM / SWMEM: `IorD`=1, with `MemRead` or `MemWrite` held high until `MemReady`. Then LWMEM → LWWB and SWMEM → IF.
- LWWB: `RegWrite`=1, `RegDst`=00, `MemtoReg`=00.
- BEQ: `ALUSrcA`=01, `PCWriteCond`=1, `PCSource`=01.
- J:
  - `PCWrite`=1; `PCSource`=10 for j/jal, 11 for jr/jalr.
  - jal/jalr additionally assert `RegWrite`, `RegDst`=10, `MemtoReg`=10.
- ERR: `PCWrite`, `EPCWrite`, `ErrTargetWrite`=1, `PCErrSource`=01. `Cause` is loaded on the transition into ERR.
- ERET: `PCWrite`=1, `PCErrSource`=10, `RegWrite`=1, `RegDst`=11, `MemtoReg`=11.
- RWB, IWB, LWWB, BEQ, J, ERR and ERET always → IF.
- Cause codes: 0 none, 1 OV, 2 RI, 3 BUS.
- Timeout:
  - The wait counter clears on entry to IF/LWMEM/SWMEM and increments on each cycle with `MemReady`=0.
  - When the counter equals `MEM_TIMEOUT` with `MemReady`=0: → ERR with cause BUS, and no `PCWrite`/`IRWrite` occurs.
  - If `MemReady`=1 in that same cycle, `MemReady` wins.
- `ALUOp`:
  - bit 3 = `OpCode[0]`.
  - bits 2:0 = 000 in IF/ID; otherwise 010 for R-type, 001 for beq, 100 for andi, 101 for slti/sltiu, else 000.
- Every output not listed for a state is 0.

## Timing
- Moore outputs, decoded from the registered state. Exceptions: the IF/LWMEM/SWMEM strobes, which also depend on `MemReady`, and `ALUSrcA`/`LuiOp`/`ExtOp`, which also depend on `Funct`/`OpCode`.
- Latency with zero wait states: R/I 4, lw 5, sw 4, beq/j 3 cycles. Each wait cycle adds 1.
- `reset` high at an edge: state=IF, counter=0, `Cause`=0.
- While `reset` is high, all outputs are 0, including the IF strobes. This holds for reset asserted mid-operation.
- `Cause` holds its value until the next ERR entry.

## Structure
- Shared package `mc_ctrl_pkg`: state encodings, opcode and funct constants, cause codes, `ALUOp` encodings.
- One sub-module, `mc_wait_timer`: clear/increment counter with a `MEM_TIMEOUT` compare, output `timeout`.

## Test plan
- Reset, then addi (0x08) with `MemReady` tied high → IF,ID,IEX,IWB; `RegWrite` pulses once in cycle 4.
- lw with `MemReady` low for 3 cycles in LWMEM → 8 cycles total; `MemRead` high for all 4 LWMEM cycles.
- `MemReady` never asserted in IF, `MEM_TIMEOUT`=15 → ERR after 16 IF cycles, `Cause`=3, no `IRWrite`.
- Opcode 0x3f → ERR from ID, `Cause`=2; next instruction 0x01 → ERET with `PCErrSource`=10.
- add with `Err`=1 in REX → ERR, `Cause`=1, no `RegWrite`. jalr → J with `PCSource`=11 and `RegDst`=10.
- `reset` asserted in LWMEM → all outputs 0 that cycle, IF on the next cycle, `Cause`=0.
